// File: rtl/dm_ctrl.sv
// -----------------------------------------------------------------------------
// dm_ctrl -- data-memory responder for the MEM stage of the single-cycle CPU.
//
// Word-organised RAM with sub-word store merging (sw/sh/sb) and combinational
// sign/zero-extended loads (lw/lh/lhu/lb/lbu). Misaligned, illegal-type or
// out-of-range accesses are blocked from the RAM, and the first one is
// captured in sticky error registers that only reset clears.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high reset (clears RAM and errors)
//   PC       in   32  PC of the instruction in MEM (write log only)
//   Addr     in   32  byte address from the ALU
//   WD       in   32  store data; sub-word lanes come from the LSBs
//   DMWr     in   1   store enable
//   DMRe     in   1   load enable (only qualifies the fault check)
//   DMtype   in   3   000 w, 001 h, 010 b, 011 bu, 100 hu; 101..111 illegal
//   RD       out  32  extended load data, combinational
//   AddrErr  out  1   sticky fault flag
//   ErrAddr  out  32  Addr of the first faulting access
// -----------------------------------------------------------------------------
module dm_ctrl #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        DMWr,
  input  logic        DMRe,
  input  logic [2:0]  DMtype,
  output logic [31:0] RD,
  output logic        AddrErr,
  output logic [31:0] ErrAddr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_BYTE  = 3'b010,
    DM_BYTEU = 3'b011,
    DM_HALFU = 3'b100
  } dm_type_e;

  logic [31:0]           mem [DEPTH];

  logic [31:0]           off;
  logic                  borrow;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  inrange;
  logic                  aligned;
  logic                  fault;
  logic                  store_ok;
  logic [31:0]           word;
  logic [31:0]           byte_sh;
  logic [31:0]           half_sh;
  logic [31:0]           lane_mask;
  logic [31:0]           lane_data;
  logic [31:0]           merged;

  // The borrow of the subtraction is the "Addr below BASE_ADDR" test; it keeps
  // the range check free of a constant compare when BASE_ADDR is zero.
  assign {borrow, off} = {1'b0, Addr} - {1'b0, BASE_ADDR};
  assign idx      = off[DEPTH_LOG2+1:2];
  assign lane     = off[1:0];
  assign inrange  = !borrow && (off[31:DEPTH_LOG2+2] == '0);
  assign fault    = (DMWr | DMRe) & ~(inrange & aligned);
  assign store_ok = DMWr & ~fault;

  assign word    = mem[idx];
  assign byte_sh = word >> {lane, 3'b000};
  assign half_sh = word >> {lane[1], 4'b0000};
  assign merged  = (word & ~lane_mask) | (lane_data & lane_mask);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    aligned   = 1'b0;
    RD        = '0;
    lane_mask = '1;
    lane_data = WD;
    case (DMtype)
      DM_WORD: begin
        aligned = (lane == 2'b00);
        RD      = word;
      end
      DM_HALF, DM_HALFU: begin
        aligned   = ~lane[0];
        RD        = (DMtype == DM_HALF) ? {{16{half_sh[15]}}, half_sh[15:0]}
                                        : {16'h0000, half_sh[15:0]};
        lane_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        lane_data = {2{WD[15:0]}};
      end
      DM_BYTE, DM_BYTEU: begin
        aligned   = 1'b1;
        RD        = (DMtype == DM_BYTE) ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                        : {24'h000000, byte_sh[7:0]};
        lane_mask = 32'h0000_00FF << {lane, 3'b000};
        lane_data = {4{WD[7:0]}};
      end
      default: ;  // illegal type: misaligned, reads 0
    endcase
    if (!inrange) RD = '0;
  end

  // NOTE: the RAM is deliberately reset word by word because reads must
  // return 0 after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store_ok) begin
      // NOTE: non-blocking, so same-cycle readers see the old word until the
      // edge has passed.
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AddrErr <= 1'b0;
      ErrAddr <= '0;
    end else if (fault && !AddrErr) begin
      AddrErr <= 1'b1;
      ErrAddr <= Addr;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_ctrl -- self-checking bench for dm_ctrl (default parameters).
// Reference model: a little-endian byte array of 4 KiB plus a sticky error
// record; loads and stores are computed byte by byte from the address rules.
// -----------------------------------------------------------------------------
module tb_dm_ctrl;

  localparam int MEM_BYTES = 4096;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        DMWr;
  logic        DMRe;
  logic [2:0]  DMtype;
  logic [31:0] RD;
  logic        AddrErr;
  logic [31:0] ErrAddr;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mb [MEM_BYTES];
  logic        err_m;
  logic [31:0] erraddr_m;

  dm_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .PC      (PC),
    .Addr    (Addr),
    .WD      (WD),
    .DMWr    (DMWr),
    .DMRe    (DMRe),
    .DMtype  (DMtype),
    .RD      (RD),
    .AddrErr (AddrErr),
    .ErrAddr (ErrAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
    err_m     = 1'b0;
    erraddr_m = 32'h0;
  endtask

  function automatic bit m_inrange(input logic [31:0] a);
    return a < MEM_BYTES;
  endfunction

  function automatic bit m_aligned(input logic [31:0] a, input logic [2:0] t);
    case (t)
      3'd0:       return (a % 4) == 0;
      3'd1, 3'd4: return (a % 2) == 0;
      3'd2, 3'd3: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] t);
    int w;
    int h;
    logic [15:0] hv;
    logic [7:0]  bv;
    if (!m_inrange(a)) return 32'h0;
    w  = int'(a) & ~3;   // misaligned word reads see the containing word
    h  = int'(a) & ~1;   // misaligned half reads see the containing half
    hv = {mb[h+1], mb[h]};
    bv = mb[int'(a)];
    case (t)
      3'd0:    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
      3'd1:    return {{16{hv[15]}}, hv};
      3'd4:    return {16'h0, hv};
      3'd2:    return {{24{bv[7]}}, bv};
      3'd3:    return {24'h0, bv};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [2:0] t,
                            input logic we, input logic re, input logic [31:0] wd);
    bit flt;
    int n;
    flt = (we || re) && !(m_inrange(a) && m_aligned(a, t));
    if (we && !flt) begin
      n = (t == 3'd0) ? 4 : ((t == 3'd1 || t == 3'd4) ? 2 : 1);
      for (int k = 0; k < n; k++) mb[int'(a) + k] = wd[8*k +: 8];
    end
    if (flt && !err_m) begin
      err_m     = 1'b1;
      erraddr_m = a;
    end
  endtask

  // ---------------- stimulus ----------------
  // Called shortly after a rising edge: apply inputs, check the combinational
  // load before the next edge, clock, then check load and error registers.
  task automatic op(input logic [31:0] a, input logic [2:0] t, input logic we,
                    input logic re, input logic [31:0] wd, input string tag);
    Addr = a; DMtype = t; DMWr = we; DMRe = re; WD = wd; PC = PC + 32'd4;
    #1;
    check({tag, ":rd_pre"}, RD, m_read(a, t));
    @(posedge clk);
    model_edge(a, t, we, re, wd);
    #1;
    check({tag, ":rd_post"}, RD, m_read(a, t));
    check({tag, ":err"}, {31'b0, AddrErr}, {31'b0, err_m});
    check({tag, ":erraddr"}, ErrAddr, erraddr_m);
  endtask

  task automatic pulse_reset();
    DMWr = 1'b0; DMRe = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  t;
    reset = 1'b0; PC = 32'h0; Addr = 32'h0; WD = 32'h0;
    DMWr = 1'b0; DMRe = 1'b0; DMtype = 3'd0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("reset:rd", RD, 32'h0);
    check("reset:err", {31'b0, AddrErr}, 32'h0);
    check("reset:erraddr", ErrAddr, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // word path
    op(32'h8, 3'd0, 1, 0, 32'h1234_5678, "sw8");
    op(32'h8, 3'd0, 0, 1, 32'h0, "lw8");
    check("lw8:const", RD, 32'h1234_5678);

    // byte lanes
    op(32'h4, 3'd0, 1, 0, 32'h1122_3344, "sw4");
    op(32'h5, 3'd2, 1, 0, 32'h0000_00AB, "sb5");
    op(32'h4, 3'd0, 0, 1, 32'h0, "lw4b");
    check("sb5:word", RD, 32'h1122_AB44);
    op(32'h5, 3'd2, 0, 1, 32'h0, "lb5");
    check("lb5:const", RD, 32'hFFFF_FFAB);
    op(32'h5, 3'd3, 0, 1, 32'h0, "lbu5");
    check("lbu5:const", RD, 32'h0000_00AB);

    // half lanes
    op(32'h6, 3'd1, 1, 0, 32'hFFFF_8001, "sh6");
    op(32'h4, 3'd0, 0, 1, 32'h0, "lw4h");
    check("sh6:word", RD, 32'h8001_AB44);
    op(32'h6, 3'd1, 0, 1, 32'h0, "lh6");
    check("lh6:const", RD, 32'hFFFF_8001);
    op(32'h6, 3'd4, 0, 1, 32'h0, "lhu6");
    check("lhu6:const", RD, 32'h0000_8001);

    // faults
    op(32'h2, 3'd0, 1, 0, 32'hDEAD_BEEF, "sw2");
    check("sw2:err", {31'b0, AddrErr}, 32'h1);
    check("sw2:erraddr", ErrAddr, 32'h2);
    op(32'h0, 3'd0, 0, 1, 32'h0, "lw0");
    check("sw2:nowrite", RD, 32'h0);
    op(32'h3, 3'd1, 0, 1, 32'h0, "lh3");
    check("lh3:erraddr", ErrAddr, 32'h2);
    op(32'h1000, 3'd0, 0, 1, 32'h0, "lw1000");
    check("lw1000:const", RD, 32'h0);

    // reset between edges
    op(32'hC, 3'd0, 1, 0, 32'h5555_AAAA, "swC");
    Addr = 32'h8; DMtype = 3'd0; DMWr = 1'b0; DMRe = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midreset:rd", RD, 32'h0);
    check("midreset:err", {31'b0, AddrErr}, 32'h0);
    check("midreset:erraddr", ErrAddr, 32'h0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    op(32'h8, 3'd0, 0, 1, 32'h0, "lw8r");
    check("lw8r:const", RD, 32'h0);

    // read during write
    op(32'h10, 3'd0, 1, 0, 32'hCAFE_F00D, "sw10a");
    Addr = 32'h10; DMtype = 3'd0; DMWr = 1'b1; DMRe = 1'b1; WD = 32'h0BAD_BEEF;
    #1;
    check("rdw:old", RD, 32'hCAFE_F00D);
    @(posedge clk);
    model_edge(32'h10, 3'd0, 1, 1, 32'h0BAD_BEEF);
    #1;
    check("rdw:new", RD, 32'h0BAD_BEEF);

    // randomized traffic, fresh error state per batch
    for (int b = 0; b < 4; b++) begin
      pulse_reset();
      for (int n = 0; n < 150; n++) begin
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 7));
          default: a = 32'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 7) == 0) t = 3'($urandom_range(5, 7));
        else                           t = 3'($urandom_range(0, 4));
        op(a, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
